instr_fetch_ctrl: RTL and testbench

- Fetch controller for KGP-miniRISC; closes the loop around the program counter register.
- Consumes the current PC (`instr_addr`) and drives `next_addr` back into the PC, which loads it every clock. It therefore holds, advances or redirects the PC each cycle.
- Runs a req/ack handshake to instruction memory and presents fetched instructions to decode through a one-entry valid/ready buffer.
- Handles branch redirects, including ones that arrive while a memory request is outstanding, and halt.

---
 rtl/instr_fetch_ctrl_if.sv | 31 +++
 rtl/instr_fetch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus of instr_fetch_ctrl: PC loop, instruction memory handshake,
// decode buffer, branch redirect and halt.
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  instr_addr;
    logic [ADDR_W-1:0]  next_addr;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_pc;
    logic               dec_ready;
    logic               br_taken;
    logic [ADDR_W-1:0]  br_target;
    logic               halt;
    logic               halted;

    modport master (
        input  instr_addr, imem_ack, imem_rdata, dec_ready, br_taken, br_target, halt,
        output next_addr, imem_req, imem_addr, instr_valid, instr_out, instr_pc, halted
    );

    modport slave (
        output instr_addr, imem_ack, imem_rdata, dec_ready, br_taken, br_target, halt,
        input  next_addr, imem_req, imem_addr, instr_valid, instr_out, instr_pc, halted
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// KGP-miniRISC fetch controller: drives the PC, fetches over req/ack, buffers one instruction.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
//
// state   | meaning
// S_BOOT  | first cycle out of reset, steps the all-ones PC to 0
// S_IDLE  | no request outstanding; redirect, halt or start a fetch
// S_WAIT  | request outstanding, data will be kept
// S_DRAIN | request outstanding after a redirect, data will be dropped
// S_HALT  | fetching stopped until reset
module instr_fetch_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_ctrl_if.master  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_WAIT,
        S_DRAIN,
        S_HALT
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t             state_q, state_d;
    logic               instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0] instr_out_q, instr_out_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic [ADDR_W-1:0]  redir_q, redir_d;
    logic [ADDR_W-1:0]  next_addr_c;
    logic               capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_BOOT;
            instr_valid_q <= 1'b0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            redir_q       <= '0;
        end else begin
            state_q       <= state_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            redir_q       <= redir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        next_addr_c = bus.instr_addr;
        redir_d     = redir_q;
        capture     = 1'b0;
        case (state_q)
            S_BOOT: begin
                next_addr_c = bus.instr_addr + ADDR_ONE;
                state_d     = S_IDLE;
            end
            S_IDLE: begin
                if (bus.br_taken) begin
                    next_addr_c = bus.br_target;
                end else if (bus.halt) begin
                    state_d = S_HALT;
                end else if (!instr_valid_q || bus.dec_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_ack && bus.br_taken) begin
                    next_addr_c = bus.br_target;
                    state_d     = S_IDLE;
                end else if (bus.imem_ack) begin
                    capture     = 1'b1;
                    next_addr_c = bus.instr_addr + ADDR_ONE;
                    state_d     = S_IDLE;
                end else if (bus.br_taken) begin
                    redir_d = bus.br_target;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.br_taken) begin
                    redir_d = bus.br_target;
                end
                // A redirect landing on the ack cycle itself beats the stored one.
                if (bus.imem_ack) begin
                    next_addr_c = bus.br_taken ? bus.br_target : redir_q;
                    state_d     = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_comb begin
        instr_valid_d = instr_valid_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        if (bus.br_taken) begin
            instr_valid_d = 1'b0;
        end else if (capture) begin
            instr_valid_d = 1'b1;
            instr_out_d   = bus.imem_rdata;
            instr_pc_d    = bus.instr_addr;
        end else if (bus.dec_ready && instr_valid_q) begin
            instr_valid_d = 1'b0;
        end
    end

    assign bus.next_addr   = next_addr_c;
    assign bus.imem_req    = (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign bus.imem_addr   = bus.instr_addr;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_out   = instr_out_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.halted      = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Neither condition can hold in S_HALT, so both counters freeze there.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (capture) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (((state_q == S_IDLE) || (state_q == S_WAIT)) && (next_addr_c == bus.instr_addr)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized scoreboard bench for instr_fetch_ctrl with a transaction-level fetch model.
module tb_instr_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_ctrl_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    instr_fetch_ctrl #(.ADDR_W(32), .INSTR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // PC register closing the loop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.instr_addr <= 32'hFFFF_FFFF;
        else     bus.instr_addr <= bus.next_addr;
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          consumed = 0;
    int          captures = 0;
    int          since_rst = 0;
    logic [31:0] exp_fetch;
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_lat;
    int          mem_cnt;
    bit          req_dirty;
    logic [31:0] req_tgt;
    bit          prev_valid;
    bit          prev_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_00A0 + a;
    endfunction

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(0, 5))
            0: t = 32'h0000_0010;
            1: t = 32'h0000_0040;
            2: t = 32'h0000_0080;
            3: t = 32'hFFFF_FFFF;
            4: t = 32'hFFFF_FFFE;
            default: t = $urandom_range(0, 255);
        endcase
        return t;
    endfunction

    // Scoreboard monitor: every accepted instruction must match the model's queue head.
    always @(negedge clk) begin
        if (!rst) begin
            #2;
            if (bus.instr_valid && bus.dec_ready) begin
                chk("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    ent_t e;
                    e = sbq.pop_front();
                    chk("instr_out", bus.instr_out, e.instr);
                    chk("instr_pc", bus.instr_pc, e.pc);
                end
                consumed++;
            end
        end
    end

    task automatic step(input bit rand_en);
        bit          req;
        bit          ack;
        bit          br;
        bit          rdy;
        logic [31:0] tgt;
        @(negedge clk);
        since_rst++;
        req = bus.imem_req;
        if (since_rst == 3) chk("first_req", 32'(req), 32'd1);
        if (req) chk("imem_addr_pc", bus.imem_addr, bus.instr_addr);
        if (mem_busy) begin
            chk("req_held", 32'(req), 32'd1);
            if (req) chk("addr_stable", bus.imem_addr, mem_addr);
            else mem_busy = 1'b0;
        end else if (req) begin
            chk("fetch_addr", bus.imem_addr, exp_fetch);
            chk("req_buf_free", 32'(prev_valid && !prev_ready), 32'd0);
            mem_busy  = 1'b1;
            mem_addr  = bus.imem_addr;
            mem_lat   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            mem_cnt   = 0;
            req_dirty = 1'b0;
        end
        ack = mem_busy && (mem_cnt == mem_lat);
        br  = rand_en && (since_rst > 3) && ($urandom_range(0, 7) == 0);
        tgt = pick_target();
        rdy = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.imem_ack   = ack;
        bus.imem_rdata = ack ? mem_word(mem_addr) : $urandom;
        bus.br_taken   = br;
        bus.br_target  = tgt;
        bus.dec_ready  = rdy;
        prev_valid = bus.instr_valid;
        prev_ready = rdy;
        #3;
        if (br) sbq.delete();
        if (mem_busy) begin
            if (ack) begin
                if (br) exp_fetch = tgt;
                else if (req_dirty) exp_fetch = req_tgt;
                else begin
                    sbq.push_back('{instr: mem_word(mem_addr), pc: mem_addr});
                    exp_fetch = mem_addr + 32'd1;
                    captures++;
                end
                mem_busy = 1'b0;
            end else begin
                mem_cnt++;
                if (br) begin
                    req_dirty = 1'b1;
                    req_tgt   = tgt;
                end
            end
        end else if (br) begin
            exp_fetch = tgt;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.br_taken   = 1'b0;
        bus.br_target  = '0;
        bus.dec_ready  = 1'b0;
        bus.halt       = 1'b0;
        sbq.delete();
        mem_busy   = 1'b0;
        exp_fetch  = 32'd0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        captures   = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_out", bus.instr_out, 32'd0);
        chk("rst_pc", bus.instr_pc, 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pcreg", bus.instr_addr, 32'hFFFF_FFFF);
        rst = 1'b0;
        #1;
        chk("boot_next", bus.next_addr, 32'd0);
        since_rst = 1;
    endtask

    initial begin
        logic [31:0] pc_hold;
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] fc_hold;
        logic [31:0] sc_hold;
`endif
        do_reset();
        repeat (3000) step(1'b1);

        bus.halt = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.halted) break;
            step(1'b0);
        end
        chk("halt_enter", 32'(bus.halted), 32'd1);
        pc_hold = bus.instr_addr;
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, 32'(captures));
        fc_hold = fetch_cnt;
        sc_hold = stall_cnt;
`endif
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            chk("halt_req", 32'(bus.imem_req), 32'd0);
            chk("halt_pc", bus.instr_addr, pc_hold);
            chk("halt_next", bus.next_addr, pc_hold);
        end
        chk("halt_stay", 32'(bus.halted), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt_frz", fetch_cnt, fc_hold);
        chk("stall_cnt_frz", stall_cnt, sc_hold);
`endif
        bus.halt = 1'b0;

        do_reset();
        repeat (400) step(1'b1);
        chk("liveness", 32'(consumed > 100), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
